// File: rtl/dma_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dma_controller
//  Purpose  : Single-channel memory-to-memory DMA engine. Software programs
//             SRC, DST and LEN through a small register port and starts the
//             transfer from CTRL. The engine then requests the bus and copies
//             LEN 32-bit words, one read beat followed by one write beat per
//             word. Completion sets done, which can raise a level interrupt.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             reg_sel, wdata,
//             wenable, rdata      - register access (0 SRC,1 DST,2 LEN,3 CTRL)
//             bus_req, bus_gnt    - bus master request / grant
//             m_addr, m_wdata,
//             m_wenable, m_rdata  - bus master data path
//             irq                 - done AND irq_en
//  Revision : 1.0 - initial release
// ============================================================================
module dma_controller #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic        wenable,
  output logic [31:0] rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wenable,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [1:0] SEL_SRC  = 2'd0;
  localparam logic [1:0] SEL_DST  = 2'd1;
  localparam logic [1:0] SEL_LEN  = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  logic [1:0]           r_state;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_hold;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_done;
  logic                 r_irq_en;

  logic w_busy;
  logic w_ctrl_wr;
  logic w_start;
  logic w_len_zero;
  logic w_beat;
  logic w_last;

  assign w_busy     = (r_state != IDLE);
  assign w_ctrl_wr  = wenable && (reg_sel == SEL_CTRL);
  assign w_start    = w_ctrl_wr && wdata[0] && !w_busy;
  assign w_len_zero = (r_len == '0);
  assign w_beat     = (r_state == WRITE) && bus_gnt;
  assign w_last     = (r_len == LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_hold   <= '0;
      r_len    <= '0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      // A write that acknowledges done (bit1) may enable the interrupt but
      // never disables it, so a plain acknowledge keeps irq_en intact.
      if (w_ctrl_wr) begin
        r_irq_en <= wdata[1] ? (r_irq_en | wdata[2]) : wdata[2];
      end

      // Clear is applied first; a same-edge completion or zero-length start
      // then sets done again, which is the intended ordering.
      if (w_ctrl_wr && wdata[1]) begin
        r_done <= 1'b0;
      end
      if ((w_start && w_len_zero) || (w_beat && w_last)) begin
        r_done <= 1'b1;
      end

      // Address and count registers are frozen while a transfer runs.
      if (wenable && !w_busy) begin
        case (reg_sel)
          SEL_SRC: r_src <= {wdata[31:2], 2'b00};
          SEL_DST: r_dst <= {wdata[31:2], 2'b00};
          SEL_LEN: r_len <= wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      case (r_state)
        IDLE: begin
          if (w_start && !w_len_zero) begin
            r_state <= ARB;
          end
        end
        ARB: begin
          if (bus_gnt) begin
            r_state <= READ;
          end
        end
        READ: begin
          if (bus_gnt) begin
            r_hold  <= m_rdata;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (bus_gnt) begin
            r_src   <= r_src + 32'd4;
            r_dst   <= r_dst + 32'd4;
            r_len   <= r_len - LEN_WIDTH'(1);
            r_state <= w_last ? IDLE : READ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus-side outputs are pure decodes of state so that an asynchronous reset
  // removes the request and any write strobe without waiting for a clock.
  always_comb begin
    bus_req   = w_busy;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    m_wenable = 4'h0;
    case (r_state)
      READ: begin
        m_addr = r_src;
      end
      WRITE: begin
        m_addr    = r_dst;
        m_wdata   = r_hold;
        m_wenable = bus_gnt ? 4'hF : 4'h0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      SEL_SRC:  rdata = r_src;
      SEL_DST:  rdata = r_dst;
      SEL_LEN:  rdata = 32'(r_len);
      default:  rdata = {29'd0, r_irq_en, r_done, w_busy};
    endcase
  end

  assign irq = r_done && r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dma_controller
//  Purpose  : Self-checking bench for dma_controller. A behavioural memory
//             returns an address-derived word; each transfer is predicted as
//             a list of (address, data) writes plus final register values,
//             and its duration as 2*LEN+1 granted clock edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_controller;

  localparam int LEN_WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  reg_sel;
  logic [31:0] wdata;
  logic        wenable;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wenable;
  logic [31:0] m_rdata;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] obs_q[$];

  dma_controller #(.LEN_WIDTH(LEN_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_sel   (reg_sel),
    .wdata     (wdata),
    .wenable   (wenable),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wenable (m_wenable),
    .m_rdata   (m_rdata),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  assign m_rdata = mem_word(m_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, committed at the
  // following rising edge. A full strobe seen here is a write that commits.
  task automatic cycle(input logic we, input logic [1:0] sel, input logic [31:0] d, input logic g);
    @(negedge clk);
    wenable = we;
    reg_sel = sel;
    wdata   = d;
    bus_gnt = g;
    #1;
    if (m_wenable == 4'hF) obs_q.push_back({m_addr, m_wdata});
    if (!g) check_eq("wen_without_gnt", 32'(m_wenable), 32'd0);
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [31:0] v);
    wenable = 1'b0;
    reg_sel = sel;
    #1;
    v = rdata;
  endtask

  // mode 0: grant always high; mode 1: random grant; mode 2: grant dropped
  // for three edges while the first write beat is pending.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input logic ien, input int mode, input bit poke);
    logic [31:0] v;
    logic [31:0] sa;
    logic [31:0] da;
    logic [63:0] w;
    int need;
    int granted;
    int edges;
    logic g;
    sa = {src[31:2], 2'b00};
    da = {dst[31:2], 2'b00};
    obs_q.delete();
    cycle(1'b1, 2'd0, src, 1'b0);
    cycle(1'b1, 2'd1, dst, 1'b0);
    cycle(1'b1, 2'd2, 32'(len), 1'b0);
    cycle(1'b1, 2'd3, {29'd0, ien, 2'b00}, 1'b0);
    cycle(1'b1, 2'd3, {29'd0, ien, 2'b11}, 1'b0);
    @(posedge clk);
    #1;
    read_reg(2'd3, v);
    check_eq("start_ctrl", v, {29'd0, ien, 2'b01});
    check_eq("start_bus_req", 32'(bus_req), 32'd1);
    need    = 2 * len + 1;
    granted = 0;
    edges   = 0;
    while (granted < need && edges < 500) begin
      case (mode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 3) != 0);
        default: g = !(edges >= 2 && edges <= 4);
      endcase
      if (poke && edges == 3)      cycle(1'b1, 2'd2, 32'd9, g);
      else if (poke && edges == 4) cycle(1'b1, 2'd3, {29'd0, ien, 2'b01}, g);
      else                         cycle(1'b0, 2'd3, 32'd0, g);
      if (g) granted++;
      edges++;
      @(posedge clk);
      #1;
      read_reg(2'd3, v);
      check_eq("busy", 32'(v[0]), 32'(granted < need));
      check_eq("bus_req", 32'(bus_req), 32'(granted < need));
    end
    if (granted < need) check_eq("xfer_timeout", 32'(granted), 32'(need));
    if (mode == 0) check_eq("xfer_edges", 32'(edges), 32'(need));
    if (mode == 2) check_eq("stall_edges", 32'(edges), 32'(need + 3));
    read_reg(2'd3, v);
    check_eq("end_ctrl", v, {29'd0, ien, 2'b10});
    check_eq("end_irq", 32'(irq), 32'(ien));
    read_reg(2'd0, v);
    check_eq("end_src", v, sa + 32'(4 * len));
    read_reg(2'd1, v);
    check_eq("end_dst", v, da + 32'(4 * len));
    read_reg(2'd2, v);
    check_eq("end_len", v, 32'd0);
    check_eq("n_writes", 32'(obs_q.size()), 32'(len));
    for (int i = 0; i < len && i < obs_q.size(); i++) begin
      w = obs_q[i];
      check_eq("wr_addr", w[63:32], da + 32'(4 * i));
      check_eq("wr_data", w[31:0], mem_word(sa + 32'(4 * i)));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst     = 1'b1;
    wenable = 1'b0;
    reg_sel = 2'd0;
    wdata   = 32'd0;
    bus_gnt = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_m_wen", 32'(m_wenable), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    for (int s = 0; s < 4; s++) begin
      read_reg(2'(s), v);
      check_eq("rst_reg", v, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Basic copy with interrupt enabled
    run_xfer(32'h8000_0000, 32'hC000_0000, 3, 1'b1, 0, 1'b0);

    // Acknowledge done; irq_en must survive
    cycle(1'b1, 2'd3, 32'h2, 1'b0);
    @(posedge clk);
    #1;
    read_reg(2'd3, v);
    check_eq("clr_ctrl", v, 32'h4);
    check_eq("clr_irq", 32'(irq), 32'd0);

    // Disable the interrupt with a plain CTRL write
    cycle(1'b1, 2'd3, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    read_reg(2'd3, v);
    check_eq("irq_en_off", v, 32'h0);

    // Zero length: done at once, no bus request
    cycle(1'b1, 2'd2, 32'd0, 1'b1);
    cycle(1'b1, 2'd3, 32'h1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      read_reg(2'd3, v);
      check_eq("zlen_ctrl", v, 32'h2);
      check_eq("zlen_bus_req", 32'(bus_req), 32'd0);
      cycle(1'b0, 2'd3, 32'd0, 1'b1);
    end
    // Clear and start together with LEN==0 leaves done set
    cycle(1'b1, 2'd3, 32'h3, 1'b0);
    @(posedge clk);
    #1;
    read_reg(2'd3, v);
    check_eq("clr_start_zlen", v, 32'h2);

    // Grant stall in first write
    run_xfer(32'h0000_1000, 32'h0000_2000, 2, 1'b0, 2, 1'b0);

    // Busy protection: LEN and start written mid-transfer are ignored
    run_xfer(32'h1234_5678, 32'h0BAD_F00C, 4, 1'b1, 0, 1'b1);

    // Randomised transfers including unaligned programmed addresses
    for (int t = 0; t < 6; t++) begin
      run_xfer($urandom, $urandom, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1, 1'b0);
    end

    // Reset during a write beat, between clock edges
    cycle(1'b1, 2'd0, 32'h4000_0000, 1'b0);
    cycle(1'b1, 2'd1, 32'h5000_0000, 1'b0);
    cycle(1'b1, 2'd2, 32'd5, 1'b0);
    cycle(1'b1, 2'd3, 32'h7, 1'b1);
    cycle(1'b0, 2'd3, 32'd0, 1'b1);
    cycle(1'b0, 2'd3, 32'd0, 1'b1);
    cycle(1'b0, 2'd3, 32'd0, 1'b1);
    check_eq("pre_rst_wen", 32'(m_wenable), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("mid_rst_m_wen", 32'(m_wenable), 32'd0);
    check_eq("mid_rst_m_addr", m_addr, 32'd0);
    check_eq("mid_rst_irq", 32'(irq), 32'd0);
    for (int s = 0; s < 4; s++) begin
      read_reg(2'(s), v);
      check_eq("mid_rst_reg", v, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Block must be fully usable straight after reset
    run_xfer(32'h0000_0040, 32'h0000_0080, 1, 1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
